// File: rtl/reservoir_sequencer_pkg.sv
// Shared definitions for the reservoir sequencer: FSM state encoding,
// the unsigned 16-bit saturation limit and the sample counter width.
package reservoir_seq_pkg;

  typedef enum logic [2:0] {
    SEQ_IDLE    = 3'd0,
    SEQ_LOAD    = 3'd1,
    SEQ_KICK    = 3'd2,
    SEQ_SETTLE  = 3'd3,
    SEQ_CAPTURE = 3'd4,
    SEQ_EMIT    = 3'd5
  } seq_state_e;

  localparam int              SAT_W          = 16;
  localparam logic [SAT_W-1:0] SAT_LIMIT     = 16'hFFFF;
  localparam int              SAMPLE_COUNT_W = 16;

endpackage

// File: rtl/reservoir_sequencer_if.sv
// Bundle of the sample stream, mask write port, reservoir control/status
// and node output stream. The sequencer uses the slave view; the
// surrounding system (or a bench) uses the master view.
interface reservoir_sequencer_if #(
  parameter int NUM_VIRTUAL_NODES = 10,
  parameter int DATA_WIDTH        = 32,
  parameter int SAMPLE_WIDTH      = 16,
  parameter int MASK_WIDTH        = 16
);
  import reservoir_seq_pkg::*;

  localparam int ADDR_W = $clog2(NUM_VIRTUAL_NODES);

  logic                             s_valid;
  logic                             s_ready;
  logic signed [SAMPLE_WIDTH-1:0]   s_data;
  logic                             mask_we;
  logic [ADDR_W-1:0]                mask_addr;
  logic signed [MASK_WIDTH-1:0]     mask_wdata;
  logic                             res_en;
  logic [DATA_WIDTH-1:0]            res_din;
  logic [DATA_WIDTH-1:0]            res_dout;
  logic                             res_valid;
  logic                             m_valid;
  logic                             m_ready;
  logic [DATA_WIDTH-1:0]            m_data;
  logic                             m_last;
  logic                             busy;
  logic [SAMPLE_COUNT_W-1:0]        sample_count;

  modport slave (
    input  s_valid, s_data, mask_we, mask_addr, mask_wdata,
    input  res_dout, res_valid, m_ready,
    output s_ready, res_en, res_din, m_valid, m_data, m_last,
    output busy, sample_count
  );

  modport master (
    output s_valid, s_data, mask_we, mask_addr, mask_wdata,
    output res_dout, res_valid, m_ready,
    input  s_ready, res_en, res_din, m_valid, m_data, m_last,
    input  busy, sample_count
  );

endinterface

// File: rtl/reservoir_sequencer_mask_mult.sv
// Combinational masked-input generator: signed sample times signed mask,
// arithmetic right shift by FRAC_BITS, then clamp into 0..0xFFFF and
// zero-extend to DATA_WIDTH.
module reservoir_mask_mult
  import reservoir_seq_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 16,
  parameter int MASK_WIDTH   = 16,
  parameter int FRAC_BITS    = 8,
  parameter int DATA_WIDTH   = 32
) (
  input  logic signed [SAMPLE_WIDTH-1:0] sample,
  input  logic signed [MASK_WIDTH-1:0]   coef,
  output logic        [DATA_WIDTH-1:0]   masked
);

  localparam int PROD_W = SAMPLE_WIDTH + MASK_WIDTH;

  logic signed [PROD_W-1:0] prod;
  logic signed [PROD_W-1:0] shifted;

  // Negative results clamp to zero; anything above the 16-bit range pins
  // at the limit. Sign bit checked first so the magnitude test only sees
  // non-negative values.
  function automatic logic [SAT_W-1:0] sat_u16(input logic signed [PROD_W-1:0] v);
    if (v[PROD_W-1])
      sat_u16 = '0;
    else if (|v[PROD_W-2:SAT_W])
      sat_u16 = SAT_LIMIT;
    else
      sat_u16 = v[SAT_W-1:0];
  endfunction

  assign prod    = sample * coef;
  assign shifted = prod >>> FRAC_BITS;
  assign masked  = {{(DATA_WIDTH-SAT_W){1'b0}}, sat_u16(shifted)};

endmodule

// File: rtl/reservoir_sequencer.sv
// Reservoir sequencer top: expands each accepted sample into
// NUM_VIRTUAL_NODES masked reservoir updates and forwards each node
// output downstream. Owns the input-mask register file.
// Optional feature macro: RESERVOIR_SEQ_WARMUP_EN suppresses the node
// outputs of the first WARMUP_SAMPLES samples after reset.
module reservoir_sequencer
  import reservoir_seq_pkg::*;
#(
  parameter int NUM_VIRTUAL_NODES = 10,
  parameter int DATA_WIDTH        = 32,
  parameter int SAMPLE_WIDTH      = 16,
  parameter int MASK_WIDTH        = 16,
  parameter int FRAC_BITS         = 8,
  parameter int WARMUP_SAMPLES    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  reservoir_sequencer_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_VIRTUAL_NODES);

`ifdef RESERVOIR_SEQ_WARMUP_EN
  localparam bit WARMUP_EN = 1'b1;
`else
  localparam bit WARMUP_EN = 1'b0;
`endif

  localparam logic [2:0] ST_IDLE    = SEQ_IDLE;
  localparam logic [2:0] ST_LOAD    = SEQ_LOAD;
  localparam logic [2:0] ST_KICK    = SEQ_KICK;
  localparam logic [2:0] ST_SETTLE  = SEQ_SETTLE;
  localparam logic [2:0] ST_CAPTURE = SEQ_CAPTURE;
  localparam logic [2:0] ST_EMIT    = SEQ_EMIT;

  logic [2:0]                    state;
  logic [IDX_W-1:0]              node_idx;
  logic signed [SAMPLE_WIDTH-1:0] s_hold;
  logic signed [MASK_WIDTH-1:0]  mask_mem [NUM_VIRTUAL_NODES];
  logic [DATA_WIDTH-1:0]         masked;
  logic [DATA_WIDTH-1:0]         res_din_r;
  logic [DATA_WIDTH-1:0]         m_data_r;
  logic                          m_last_r;
  logic [SAMPLE_COUNT_W-1:0]     sample_count_r;
  logic [15:0]                   warm_cnt;
  logic                          s_ready_i;
  logic                          accept;
  logic                          node_last;
  logic                          in_warmup;

  assign s_ready_i = (state == ST_IDLE) && !rst;
  assign accept    = bus.s_valid && s_ready_i;
  assign node_last = (int'(node_idx) == NUM_VIRTUAL_NODES - 1);
  // Constant-false when the warm-up feature is compiled out.
  assign in_warmup = WARMUP_EN && (int'(warm_cnt) < WARMUP_SAMPLES);

  assign bus.s_ready      = s_ready_i;
  assign bus.res_en       = (state == ST_KICK);
  assign bus.res_din      = res_din_r;
  assign bus.m_valid      = (state == ST_EMIT);
  assign bus.m_data       = m_data_r;
  assign bus.m_last       = m_last_r;
  assign bus.busy         = (state != ST_IDLE);
  assign bus.sample_count = sample_count_r;

  reservoir_mask_mult #(
    .SAMPLE_WIDTH (SAMPLE_WIDTH),
    .MASK_WIDTH   (MASK_WIDTH),
    .FRAC_BITS    (FRAC_BITS),
    .DATA_WIDTH   (DATA_WIDTH)
  ) u_mask_mult (
    .sample (s_hold),
    .coef   (mask_mem[node_idx]),
    .masked (masked)
  );

  // Held sample: data only, captured on accept and kept for the whole sample.
  always_ff @(posedge clk) begin
    if (accept) s_hold <= bus.s_data;
  end

  // Mask register file: writable only while idle, out-of-range addresses ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_VIRTUAL_NODES; i++) mask_mem[i] <= '0;
    end else if (bus.mask_we && (state == ST_IDLE) &&
                 (int'(bus.mask_addr) < NUM_VIRTUAL_NODES)) begin
      mask_mem[bus.mask_addr] <= bus.mask_wdata;
    end
  end

  // Sequencing FSM: per node LOAD -> KICK -> SETTLE -> CAPTURE -> EMIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_IDLE;
      node_idx       <= '0;
      res_din_r      <= '0;
      m_data_r       <= '0;
      m_last_r       <= 1'b0;
      sample_count_r <= '0;
      warm_cnt       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            node_idx <= '0;
            state    <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          res_din_r <= masked;
          state     <= ST_KICK;
        end
        ST_KICK:   state <= ST_SETTLE;
        ST_SETTLE: state <= ST_CAPTURE;
        ST_CAPTURE: begin
          if (bus.res_valid) begin
            m_data_r <= bus.res_dout;
            m_last_r <= node_last;
            if (!in_warmup) begin
              state <= ST_EMIT;
            end else if (node_last) begin
              sample_count_r <= sample_count_r + SAMPLE_COUNT_W'(1);
              warm_cnt       <= warm_cnt + 16'd1;
              state          <= ST_IDLE;
            end else begin
              node_idx <= node_idx + IDX_W'(1);
              state    <= ST_LOAD;
            end
          end
        end
        ST_EMIT: begin
          if (bus.m_ready) begin
            if (m_last_r) begin
              sample_count_r <= sample_count_r + SAMPLE_COUNT_W'(1);
              state          <= ST_IDLE;
            end else begin
              node_idx <= node_idx + IDX_W'(1);
              state    <= ST_LOAD;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reservoir_sequencer.sv
// Bench for reservoir_sequencer: a stand-in reservoir, a queue-based
// model of the expected reservoir updates and node outputs, a per-cycle
// compare process and directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_reservoir_sequencer;
  import reservoir_seq_pkg::*;

  localparam int NV = 10;
  localparam int DW = 32;
  localparam int SW = 16;
  localparam int MW = 16;
  localparam int FB = 8;
  localparam int WU = 2;
  localparam int AW = $clog2(NV);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  reservoir_sequencer_if #(
    .NUM_VIRTUAL_NODES(NV), .DATA_WIDTH(DW), .SAMPLE_WIDTH(SW), .MASK_WIDTH(MW)
  ) bus ();

  reservoir_sequencer #(
    .NUM_VIRTUAL_NODES(NV), .DATA_WIDTH(DW), .SAMPLE_WIDTH(SW),
    .MASK_WIDTH(MW), .FRAC_BITS(FB), .WARMUP_SAMPLES(WU)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int nchk = 0;
  int nerr = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic void fail(string name);
    nchk++;
    nerr++;
    $display("FAIL %s: event did not occur as required", name);
  endfunction

  // Stand-in reservoir: each update produces a unique word (pulse number in
  // the upper half, masked input in the lower half); optional stall.
  int unsigned env_pulses = 0;
  int stall_cfg = 0;
  int stall_cnt = 0;
  logic [DW-1:0] res_q = '0;
  always @(posedge clk) begin
    if (bus.res_en) begin
      res_q      <= bus.res_din + (DW'(env_pulses + 1) << 16);
      env_pulses <= env_pulses + 1;
      stall_cnt  <= stall_cfg;
    end else if (stall_cnt > 0) begin
      stall_cnt <= stall_cnt - 1;
    end
  end
  assign bus.res_dout  = res_q;
  assign bus.res_valid = (stall_cnt == 0);

  // Reference arithmetic for one masked input.
  function automatic int model_din(int s, int m);
    longint p;
    p = (longint'(s) * longint'(m)) >>> FB;
    if (p < 0) return 0;
    if (p > 64'sd65535) return 65535;
    return int'(p);
  endfunction

  typedef struct { int din; int node; bit last; bit emit; } pulse_t;
  typedef struct { logic [DW-1:0] data; bit last; } out_t;

  pulse_t pq[$];
  out_t   oq[$];
  int     mask_m [NV];
  int     seen_din [NV];
  int     exp_count = 0;
  bit     m_busy = 1'b0;
  bit     prev_en = 1'b0;
  int     accept_no = 0;
  int     n_pulse = 0, n_hs = 0, n_last = 0;
  int     cyc = 0, t_acc = 0, lat_en = -1, lat_mv = -1;
  pulse_t p;
  out_t   o;

  always @(posedge clk) cyc <= cyc + 1;

  // Compare process: outputs checked every cycle, model advanced afterwards.
  always @(negedge clk) begin
    if (rst) begin
      pq.delete();
      oq.delete();
      m_busy    = 1'b0;
      prev_en   = 1'b0;
      exp_count = 0;
      accept_no = 0;
      for (int i = 0; i < NV; i++) mask_m[i] = 0;
    end else begin
`ifndef RESERVOIR_SEQ_WARMUP_EN
      chk("busy", bus.busy, m_busy);
      chk("s_ready", bus.s_ready, !m_busy);
      chk("sample_count", bus.sample_count, 16'(exp_count));
`endif
      if (bus.res_en) begin
        chk("res_en_back_to_back", prev_en, 1'b0);
        if (pq.size() == 0) begin
          fail("res_en_unexpected");
        end else begin
          p = pq.pop_front();
          chk("res_din", bus.res_din, DW'(p.din));
          seen_din[p.node] = int'(bus.res_din);
          n_pulse++;
          if (lat_en < 0) lat_en = cyc - t_acc;
          if (p.emit) begin
            o.data = DW'(p.din) + (DW'(env_pulses + 1) << 16);
            o.last = p.last;
            oq.push_back(o);
          end
        end
      end
      prev_en = bus.res_en;
      if (bus.m_valid) begin
        if (lat_mv < 0) lat_mv = cyc - t_acc;
        if (oq.size() == 0) begin
          fail("m_valid_unexpected");
        end else begin
          chk("m_data", bus.m_data, oq[0].data);
          chk("m_last", bus.m_last, oq[0].last);
          if (bus.m_ready) begin
            o = oq.pop_front();
            n_hs++;
            if (o.last) begin
              n_last++;
              exp_count++;
              m_busy = 1'b0;
            end
          end
        end
      end
      if (bus.mask_we && !m_busy && int'(bus.mask_addr) < NV)
        mask_m[bus.mask_addr] = int'($signed(bus.mask_wdata));
      if (bus.s_valid && bus.s_ready) begin
        for (int i = 0; i < NV; i++) begin
          p.din  = model_din(int'($signed(bus.s_data)), mask_m[i]);
          p.node = i;
          p.last = (i == NV - 1);
          p.emit = 1'b1;
`ifdef RESERVOIR_SEQ_WARMUP_EN
          p.emit = (accept_no >= WU);
`endif
          pq.push_back(p);
        end
        accept_no++;
        m_busy = 1'b1;
        t_acc  = cyc;
        lat_en = -1;
        lat_mv = -1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mask_write(int a, int d);
    bus.mask_we    = 1'b1;
    bus.mask_addr  = AW'(a);
    bus.mask_wdata = MW'(d);
    tick();
    bus.mask_we = 1'b0;
  endtask

  task automatic send_sample(int s);
    int n = 0;
    while (!bus.s_ready && n < 200) begin tick(); n++; end
    if (!bus.s_ready) fail("s_ready_timeout");
    bus.s_valid = 1'b1;
    bus.s_data  = SW'(s);
    tick();
    bus.s_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((bus.busy || pq.size() != 0 || oq.size() != 0) && n < 2000) begin tick(); n++; end
    if (bus.busy || pq.size() != 0 || oq.size() != 0) fail("idle_timeout");
    tick();
  endtask

  task automatic clear_seen();
    for (int i = 0; i < NV; i++) seen_din[i] = -1;
  endtask

  task automatic check_reset_outputs(string tag);
    chk({tag, "_s_ready"}, bus.s_ready, 1'b0);
    chk({tag, "_busy"}, bus.busy, 1'b0);
    chk({tag, "_res_en"}, bus.res_en, 1'b0);
    chk({tag, "_res_din"}, bus.res_din, 0);
    chk({tag, "_m_valid"}, bus.m_valid, 1'b0);
    chk({tag, "_m_data"}, bus.m_data, 0);
    chk({tag, "_m_last"}, bus.m_last, 1'b0);
    chk({tag, "_sample_count"}, bus.sample_count, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_p, base_hs, base_last, saved_p;
    logic [DW-1:0] saved_d;
    int n;
    bus.s_valid = 1'b0;  bus.s_data = '0;
    bus.mask_we = 1'b0;  bus.mask_addr = '0;  bus.mask_wdata = '0;
    bus.m_ready = 1'b1;
    clear_seen();

    // Reset state
    repeat (2) @(negedge clk);
    check_reset_outputs("rst_held");
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("idle_s_ready", bus.s_ready, 1'b1);
    chk("idle_busy", bus.busy, 1'b0);
    chk("idle_sample_count", bus.sample_count, 0);
    tick();

    for (int i = 0; i < NV; i++) mask_write(i, 'h0100);

`ifdef RESERVOIR_SEQ_WARMUP_EN
    // Two warm-up samples silent, third emitted.
    base_p = n_pulse; base_hs = n_hs; base_last = n_last;
    for (int k = 0; k < 3; k++) begin send_sample('h0040); wait_idle(); end
    chk("wu_pulses", n_pulse - base_p, 30);
    chk("wu_handshakes", n_hs - base_hs, 10);
    chk("wu_last", n_last - base_last, 1);
    chk("wu_sample_count", bus.sample_count, 3);
    chk("wu_m_valid_idle", bus.m_valid, 1'b0);
`else
    // Unity masks
    base_p = n_pulse; base_hs = n_hs; base_last = n_last;
    clear_seen();
    send_sample('h0040);
    wait_idle();
    chk("t1_pulses", n_pulse - base_p, 10);
    chk("t1_handshakes", n_hs - base_hs, 10);
    chk("t1_last_count", n_last - base_last, 1);
    chk("t1_din_node0", seen_din[0], 'h40);
    chk("t1_din_node9", seen_din[9], 'h40);
    chk("t1_lat_res_en", lat_en, 2);
    chk("t1_lat_m_valid", lat_mv, 5);
    chk("t1_sample_count", bus.sample_count, 1);

    // Negative clamp and positive saturation
    mask_write(3, 'hFF00);
    clear_seen();
    send_sample('h0040);
    wait_idle();
    chk("t2_neg_clamp_node3", seen_din[3], 0);
    chk("t2_node2", seen_din[2], 'h40);
    mask_write(0, 'h7FFF);
    clear_seen();
    send_sample('h7FFF);
    wait_idle();
    chk("t2_sat_node0", seen_din[0], 'hFFFF);
    chk("t2_node1", seen_din[1], 'h7FFF);
    chk("t2_node3", seen_din[3], 0);
    chk("t2_sample_count", bus.sample_count, 3);

    // Back-pressure at node 2, with a slow reservoir
    stall_cfg = 3;
    base_hs = n_hs;
    send_sample('h0010);
    n = 0;
    while (n_hs < base_hs + 2 && n < 500) begin tick(); n++; end
    if (n_hs < base_hs + 2) fail("t3_reach_node2");
    bus.m_ready = 1'b0;
    n = 0;
    while (!bus.m_valid && n < 100) begin tick(); n++; end
    if (!bus.m_valid) fail("t3_m_valid_timeout");
    saved_d = bus.m_data;
    saved_p = n_pulse;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      chk("t3_hold_valid", bus.m_valid, 1'b1);
      chk("t3_hold_data", bus.m_data, saved_d);
    end
    chk("t3_no_kick", n_pulse, saved_p);
    chk("t3_held_low_half", saved_d[15:0], 16'h0010);
    @(posedge clk); #1;
    bus.m_ready = 1'b1;
    wait_idle();
    stall_cfg = 0;
    chk("t3_sample_count", bus.sample_count, 4);

    // Mask write while busy is dropped, while idle is applied
    clear_seen();
    send_sample('h0040);
    mask_write(1, 'h0200);
    wait_idle();
    chk("t4_busy_write_dropped", seen_din[1], 'h40);
    mask_write(1, 'h0200);
    clear_seen();
    send_sample('h0040);
    wait_idle();
    chk("t4_idle_write_applied", seen_din[1], 'h80);
    chk("t4_sample_count", bus.sample_count, 6);

    // Reset during node 5
    base_hs = n_hs;
    send_sample('h0040);
    n = 0;
    while (n_hs < base_hs + 5 && n < 500) begin tick(); n++; end
    if (n_hs < base_hs + 5) fail("t5_reach_node5");
    tick();
    tick();
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("t5_mid_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t5_after_rst_count", bus.sample_count, 0);
    chk("t5_after_rst_s_ready", bus.s_ready, 1'b1);
    tick();
    mask_write(0, 'h0200);
    for (int i = 1; i < NV; i++) mask_write(i, 'h0100);
    base_hs = n_hs;
    clear_seen();
    send_sample('h0020);
    wait_idle();
    chk("t5_restart_node0", seen_din[0], 'h40);
    chk("t5_restart_node1", seen_din[1], 'h20);
    chk("t5_restart_handshakes", n_hs - base_hs, 10);
    chk("t5_sample_count", bus.sample_count, 1);
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
